// File: rtl/iobus_seq.sv
// IO-bus transaction sequencer: runs one CONO/DATAO/CONI/DATAI at a time as
// timed clear/set or read-strobe pulses, plus IO reset, power-on and PI level encode.
module iobus_seq #(
  parameter int CLR_CYC = 2,
  parameter int GAP_CYC = 1,
  parameter int SET_CYC = 2,
  parameter int RD_CYC  = 4,
  parameter int RST_CYC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [3:9]  dev,
  input  logic [0:35] wdata,
  input  logic        iorst_req,
  output logic        ack,
  output logic        busy,
  output logic [0:35] rdata,
  output logic        iob_poweron,
  output logic        iob_reset,
  output logic        cono_clear,
  output logic        cono_set,
  output logic        datao_clear,
  output logic        datao_set,
  output logic        iob_fm_datai,
  output logic        iob_fm_status,
  output logic [3:9]  ios,
  output logic [0:35] iob_write,
  input  logic [0:35] iob_read,
  input  logic [1:7]  pi_req,
  output logic [2:0]  pi_act
);

  typedef enum logic [2:0] {IDLE, CLR, GAP, SET, RD, RST, DONE} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:9]  dev;
    logic [0:35] wdata;
  } xact_t;

  localparam logic [3:0] CLR_N = 4'(CLR_CYC - 1);
  localparam logic [3:0] GAP_N = 4'(GAP_CYC - 1);
  localparam logic [3:0] SET_N = 4'(SET_CYC - 1);
  localparam logic [3:0] RD_N  = 4'(RD_CYC - 1);
  localparam logic [3:0] RST_N = 4'(RST_CYC - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  xact_t      xq, xq_nx;
  logic       ld_rd;
  logic [2:0] pi_nx;

  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - 4'd1;
    xq_nx    = xq;
    ld_rd    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = cnt;
        if (iorst_req) begin
          state_nx = RST;
          cnt_nx   = RST_N;
        end else if (req) begin
          xq_nx.op    = op;
          xq_nx.dev   = dev;
          xq_nx.wdata = wdata;
          if (op[1]) begin
            state_nx = RD;
            cnt_nx   = RD_N;
          end else begin
            state_nx = CLR;
            cnt_nx   = CLR_N;
          end
        end
      end
      CLR: if (cnt == 4'd0) begin
        if (GAP_CYC > 0) begin
          state_nx = GAP;
          cnt_nx   = GAP_N;
        end else begin
          state_nx = SET;
          cnt_nx   = SET_N;
        end
      end
      GAP: if (cnt == 4'd0) begin
        state_nx = SET;
        cnt_nx   = SET_N;
      end
      SET: if (cnt == 4'd0) state_nx = DONE;
      RD: if (cnt == 4'd0) begin
        state_nx = DONE;
        ld_rd    = 1'b1;
      end
      RST: if (cnt == 4'd0) state_nx = IDLE;
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = cnt;
      end
      default: state_nx = IDLE;
    endcase
  end

  // lowest index wins: scan high to low so the last hit is the highest priority
  always_comb begin
    pi_nx = 3'd0;
    for (int i = 7; i >= 1; i--)
      if (pi_req[i]) pi_nx = 3'(i);
  end

  // bus outputs are decoded from the next state so they flop alongside it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      xq            <= '0;
      ack           <= 1'b0;
      rdata         <= '0;
      iob_poweron   <= 1'b0;
      iob_reset     <= 1'b0;
      cono_clear    <= 1'b0;
      cono_set      <= 1'b0;
      datao_clear   <= 1'b0;
      datao_set     <= 1'b0;
      iob_fm_datai  <= 1'b0;
      iob_fm_status <= 1'b0;
      ios           <= '0;
      iob_write     <= '0;
      pi_act        <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      xq            <= xq_nx;
      iob_poweron   <= 1'b1;
      pi_act        <= pi_nx;
      ack           <= (state_nx == DONE);
      iob_reset     <= (state_nx == RST);
      cono_clear    <= (state_nx == CLR) && (xq_nx.op == 2'b00);
      datao_clear   <= (state_nx == CLR) && (xq_nx.op == 2'b01);
      cono_set      <= (state_nx == SET) && (xq_nx.op == 2'b00);
      datao_set     <= (state_nx == SET) && (xq_nx.op == 2'b01);
      iob_fm_status <= (state_nx == RD)  && (xq_nx.op == 2'b10);
      iob_fm_datai  <= (state_nx == RD)  && (xq_nx.op == 2'b11);
      ios           <= (state_nx != IDLE && state_nx != RST) ? xq_nx.dev : '0;
      iob_write     <= (state_nx inside {CLR, GAP, SET}) ? xq_nx.wdata : '0;
      if (ld_rd) rdata <= iob_read;
    end
  end

endmodule

// File: tb/tb_iobus_seq.sv
// Bench for iobus_seq: default instance plus a GAP_CYC=0 instance on shared inputs;
// per-cycle pulse checks and an ack-driven scoreboard for dev/rdata.
module tb_iobus_seq;
  localparam int C = 2, S = 2, R = 4, RS = 8;

  logic        clk = 1'b0;
  logic        rst_n, req, iorst_req;
  logic [1:0]  op;
  logic [3:9]  dev;
  logic [0:35] wdata, iob_read;
  logic [1:7]  pi_req;

  logic        ack_a, busy_a, pon_a, rs_a, cc_a, cs_a, dc_a, ds_a, fd_a, fs_a;
  logic        ack_b, busy_b, pon_b, rs_b, cc_b, cs_b, dc_b, ds_b, fd_b, fs_b;
  logic [0:35] rdata_a, wr_a, rdata_b, wr_b;
  logic [3:9]  ios_a, ios_b;
  logic [2:0]  pi_a, pi_b;
  logic [8:0]  p_a, p_b;

  assign p_a = {cc_a, cs_a, dc_a, ds_a, fd_a, fs_a, rs_a, ack_a, busy_a};
  assign p_b = {cc_b, cs_b, dc_b, ds_b, fd_b, fs_b, rs_b, ack_b, busy_b};

  always #5 clk = ~clk;

  iobus_seq u_dut_a (
    .clk(clk), .reset(rst_n), .req(req), .op(op), .dev(dev), .wdata(wdata),
    .iorst_req(iorst_req), .ack(ack_a), .busy(busy_a), .rdata(rdata_a),
    .iob_poweron(pon_a), .iob_reset(rs_a), .cono_clear(cc_a), .cono_set(cs_a),
    .datao_clear(dc_a), .datao_set(ds_a), .iob_fm_datai(fd_a), .iob_fm_status(fs_a),
    .ios(ios_a), .iob_write(wr_a), .iob_read(iob_read), .pi_req(pi_req), .pi_act(pi_a));

  iobus_seq #(.GAP_CYC(0)) u_dut_b (
    .clk(clk), .reset(rst_n), .req(req), .op(op), .dev(dev), .wdata(wdata),
    .iorst_req(iorst_req), .ack(ack_b), .busy(busy_b), .rdata(rdata_b),
    .iob_poweron(pon_b), .iob_reset(rs_b), .cono_clear(cc_b), .cono_set(cs_b),
    .datao_clear(dc_b), .datao_set(ds_b), .iob_fm_datai(fd_b), .iob_fm_status(fs_b),
    .ios(ios_b), .iob_write(wr_b), .iob_read(iob_read), .pi_req(pi_req), .pi_act(pi_b));

  typedef struct {
    logic        rd;
    logic [6:0]  dev;
    logic [35:0] data;
  } sb_t;
  sb_t sb[$];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // write-cycle pulse vector for clear width C, gap g, set width S
  function automatic logic [8:0] wr_exp(input logic [1:0] o, input int c, input int g);
    int  e;
    logic clr, set;
    e   = C + g + S;
    clr = (c >= 1) && (c <= C);
    set = (c >= C + g + 1) && (c <= e);
    return {o == 2'b00 && clr, o == 2'b00 && set, o == 2'b01 && clr, o == 2'b01 && set,
            3'b000, c == e + 1, (c >= 1) && (c <= e + 1)};
  endfunction

  task automatic scramble();
    op    = 2'($urandom);
    dev   = 7'($urandom);
    wdata = 36'({$urandom, $urandom});
  endtask

  task automatic run_write(input logic [1:0] o, input logic [6:0] d, input logic [35:0] w);
    sb_t e;
    req = 1'b1; op = o; dev = d; wdata = w;
    e.rd = 1'b0; e.dev = d; e.data = '0;
    sb.push_back(e);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin
        req = 1'b0;
        scramble();
      end
      chk("wr_pulse_a", p_a, wr_exp(o, c, 1));
      chk("wr_pulse_b", p_b, wr_exp(o, c, 0));
      chk("wr_ios_a", ios_a, (c <= 6) ? d : 7'd0);
      chk("wr_ios_b", ios_b, (c <= 5) ? d : 7'd0);
      chk("wr_data_a", wr_a, (c <= 5) ? w : 36'd0);
      chk("wr_data_b", wr_b, (c <= 4) ? w : 36'd0);
    end
  endtask

  task automatic run_read(input logic [1:0] o, input logic [6:0] d, input logic [35:0] rd);
    sb_t e;
    logic s;
    req = 1'b1; op = o; dev = d; iob_read = ~rd;
    e.rd = 1'b1; e.dev = d; e.data = rd;
    sb.push_back(e);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        req = 1'b0;
        scramble();
      end
      iob_read = (c <= R) ? rd : ~rd;
      s = (c <= R);
      chk("rd_pulse_a", p_a, {4'b0000, o == 2'b11 && s, o == 2'b10 && s, 1'b0, c == R + 1, c <= R + 1});
      chk("rd_pulse_b", p_b, {4'b0000, o == 2'b11 && s, o == 2'b10 && s, 1'b0, c == R + 1, c <= R + 1});
      chk("rd_ios_a", ios_a, (c <= R + 1) ? d : 7'd0);
      chk("rd_wr_a", wr_a, 36'd0);
      if (c >= R + 1) chk("rd_hold_a", rdata_a, rd);
    end
  endtask

  // iorst_req and req together: reset pulse first, held req taken right after
  task automatic run_iorst(input logic [6:0] d, input logic [35:0] w);
    req = 1'b1; iorst_req = 1'b1; op = 2'b00; dev = d; wdata = w;
    for (int c = 1; c <= RS + 1; c++) begin
      tick();
      if (c == 1) iorst_req = 1'b0;
      chk("rst_pulse_a", p_a, {6'b000000, c <= RS, 1'b0, c <= RS});
      chk("rst_pulse_b", p_b, {6'b000000, c <= RS, 1'b0, c <= RS});
      chk("rst_ios_a", ios_a, 7'd0);
    end
    run_write(2'b00, d, w);
  endtask

  always @(negedge clk) begin
    if (rst_n && ack_a) begin
      if (sb.size() == 0) chk("spurious_ack", ack_a, 1'b0);
      else begin
        sb_t e;
        e = sb.pop_front();
        chk("ack_dev", ios_a, e.dev);
        if (e.rd) chk("ack_rdata", rdata_a, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  logic [6:0] pv [5] = '{7'b0010100, 7'b0000000, 7'b1111111, 7'b0000001, 7'b1000000};
  logic [2:0] pe [5] = '{3'd3, 3'd0, 3'd1, 3'd7, 3'd1};

  initial begin
    logic [2:0] prev;
    rst_n = 1'b0; req = 1'b0; iorst_req = 1'b0; op = '0; dev = '0; wdata = '0;
    iob_read = '1; pi_req = 7'h7f;
    #3;
    chk("init_pulses", p_a, 9'd0);
    chk("init_poweron", pon_a, 1'b0);
    chk("init_pi", pi_a, 3'd0);
    chk("init_rdata", rdata_a, 36'd0);
    pi_req = '0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    chk("poweron_pre", pon_a, 1'b0);
    tick();
    chk("poweron_post", pon_a, 1'b1);

    run_write(2'b00, 7'o24, 36'o123456701234);
    run_read(2'b11, 7'o55, 36'o777000111222);
    run_write(2'b01, 7'o17, 36'o000111222333);
    run_read(2'b10, 7'o3, 36'o135724670246);
    run_iorst(7'o24, 36'o765432107654);

    prev = pi_a;
    for (int i = 0; i < 5; i++) begin
      pi_req = pv[i];
      #1 chk("pi_lag", pi_a, prev);
      tick();
      chk("pi_act", pi_a, pe[i]);
      prev = pe[i];
    end

    // DATAO aborted by reset in its SET phase
    req = 1'b1; op = 2'b01; dev = 7'o33; wdata = 36'o707070707070;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req = 1'b0;
    end
    chk("abort_set", p_a, wr_exp(2'b01, 4, 1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pulses", p_a, 9'd0);
    chk("abort_ios", ios_a, 7'd0);
    chk("abort_wr", wr_a, 36'd0);
    chk("abort_rdata", rdata_a, 36'd0);
    chk("abort_pi", pi_a, 3'd0);
    chk("abort_poweron", pon_a, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    chk("rel_poweron_pre", pon_a, 1'b0);
    tick();
    chk("rel_poweron", pon_a, 1'b1);
    for (int c = 0; c < 8; c++) begin
      chk("rel_idle", p_a, 9'd0);
      tick();
    end
    pi_req = '0;

    run_read(2'b11, 7'o101, 36'o4);
    tick();
    chk("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/iobus_seq.md
# iobus_seq

IO-bus transaction sequencer that sits between the processor's IOT logic and the master side of the IO bus connect block. It accepts one CONO/DATAO/CONI/DATAI request at a time and drives the device select lines and data. For writes it generates the clear-then-set pulse pair; for reads it generates the read strobe and samples the returned word. It also generates IO reset pulses, drives power-on, and registers the highest-priority PI request level.

## Interface
Parameters:
- CLR_CYC, 2: width of the clear pulse in cycles (1..15).
- GAP_CYC, 1: dead cycles between clear and set (0..15; 0 = no gap).
- SET_CYC, 2: width of the set pulse in cycles (1..15).
- RD_CYC, 4: width of the DATAI/CONI strobe in cycles (1..15).
- RST_CYC, 8: width of the iob_reset pulse in cycles (1..15).

Ports:
- clk, in, 1: the single clock; all logic is rising-edge.
- reset, in, 1: asynchronous, active-low reset.
- req, in, 1: level request; sampled only in IDLE.
- op, in, 2: operation; 00 CONO, 01 DATAO, 10 CONI, 11 DATAI.
- dev, in, [3:9]: device code.
- wdata, in, [0:35]: write word.
- iorst_req, in, 1: request an IO reset pulse; sampled only in IDLE.
- ack, out, 1: one-cycle completion pulse.
- busy, out, 1: high when the state is not IDLE.
- rdata, out, [0:35]: last sampled read word.
- iob_poweron, out, 1: bus power-on.
- iob_reset, out, 1: bus IO reset.
- cono_clear / cono_set / datao_clear / datao_set, out, 1 each: write pulses.
- iob_fm_datai / iob_fm_status, out, 1 each: read strobes.
- ios, out, [3:9]: device select on the bus.
- iob_write, out, [0:35]: write data on the bus.
- iob_read, in, [0:35]: read data from the bus.
- pi_req, in, [1:7]: PI requests from the bus.
- pi_act, out, 3: highest-priority active PI level, 0 = none.

## Operation
- States: IDLE, CLR, GAP, SET, RD, RST, DONE. A 4-bit down-counter times each state.
- In IDLE:
  - iorst_req=1 goes to RST. iorst_req has priority over req when both are high.
  - Otherwise req=1 latches op, dev and wdata, then goes to CLR for op 0x or RD for op 1x.
  - The requester may change op, dev and wdata after the accept cycle.
- CLR: assert cono_clear (op 00) or datao_clear (op 01) for CLR_CYC cycles. Then go to GAP if GAP_CYC>0, else to SET.
- GAP: no pulses for GAP_CYC cycles, then SET.
- SET: assert cono_set or datao_set for SET_CYC cycles, then DONE.
- RD: assert iob_fm_status (op 10) or iob_fm_datai (op 11) for RD_CYC cycles. On the last RD cycle, register iob_read into rdata. Then DONE.
- RST: assert iob_reset for RST_CYC cycles, then IDLE. No ack is given for a reset.
- DONE: ack=1 for one cycle, then IDLE.
- Back-to-back requests: if req is still high in the following IDLE cycle, a new transaction is accepted there. Requesters drop req on the cycle ack is seen.
- Bus drive rules:
  - ios = latched dev in every state except IDLE and RST; 0 otherwise.
  - iob_write = latched wdata in CLR/GAP/SET; 0 otherwise. As a result iob_read during reads carries device data only.
- iob_poweron: registered; 0 while reset is asserted, 1 from the first clk edge after reset deasserts.
- pi_act: registered every cycle. It is the lowest index i with pi_req[i]=1 (level 1 is highest priority), or 0 when pi_req=0.
- All bus pulses are registered outputs, so they are glitch-free.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled high.
- Write (op 0x):
  - Clear is high in cycles 1..C.
  - Gap occupies the next G cycles.
  - Set is high in cycles C+G+1..C+G+S.
  - ack is high in cycle C+G+S+1.
  - With the defaults, ack is at cycle 6.
- Read (op 1x):
  - Strobe is high in cycles 1..R.
  - rdata is valid from cycle R+1, the ack cycle, and holds until the next read.
  - With the defaults, ack is at cycle 5.
- Reset pulse: iob_reset is high in cycles 1..RST_CYC; IDLE in cycle RST_CYC+1.
- busy is high from cycle 1 through the ack cycle (or through the last RST cycle).
- pi_act lags pi_req by one cycle.
- reset asserted at any point, including mid-transaction:
  - Immediately forces IDLE.
  - All outputs go to 0, including rdata, pi_act, iob_poweron and ack.
  - No ack is given for the aborted transaction.
- req arriving in any non-IDLE state is ignored until IDLE.

## Test plan
- CONO, defaults, dev=7'o24, wdata=36'o123456701234:
  - cono_clear high cycles 1–2, nothing in cycle 3, cono_set high cycles 4–5, ack in cycle 6.
  - ios=7'o24 and iob_write=wdata in cycles 1–5; datao_* stay 0.
- DATAI with iob_read=36'o777000111222 during the strobe:
  - iob_fm_datai high cycles 1–4, ack in cycle 5, rdata=36'o777000111222.
  - iob_write=0 throughout.
- req and iorst_req both high in IDLE:
  - iob_reset high for 8 cycles with no ack.
  - The held req is then accepted the cycle after RST ends.
- GAP_CYC=0 DATAO: datao_set rises in the cycle immediately after the last datao_clear cycle; ack at cycle 5.
- reset pulled low during SET of a DATAO:
  - All outputs are 0 asynchronously and no ack follows.
  - After release, iob_poweron=1 one edge later and the state is IDLE.
- pi_req=7'b0010100 (levels 3 and 5): pi_act=3 one cycle later; pi_req=0 gives pi_act=0.
